// File: rtl/act_pingpong_sched_if.sv
// ---------------------------------------------------------------------------
// act_pingpong_sched_if
//   Bundles every non-clock signal between the ping-pong scheduler, the
//   activation writer, the PE and the dual-port Block_RAM.
//   Modports:
//     slave  - the scheduler itself
//     master - the surrounding environment (writer, PE and BRAM together)
//   Signal groups:
//     writer : wr_req, wr_grant, wr_bank, wr_done, wr_addr, wr_ce, wr_we, wr_d
//     PE     : sync_vld, sync_bank, sync_ack, rd_done, rd_addr, rd_ce, rd_q
//     BRAM   : bram_addr1/ce1/we1/d1 (write port), bram_addr0/ce0/q0 (read port)
//     status : frames_done, err_proto
// ---------------------------------------------------------------------------
interface act_pingpong_sched_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16
);
  // writer side
  logic              wr_req;
  logic              wr_grant;
  logic              wr_bank;
  logic              wr_done;
  logic [AWIDTH-1:0] wr_addr;
  logic              wr_ce;
  logic              wr_we;
  logic [DWIDTH-1:0] wr_d;
  // PE side
  logic              sync_vld;
  logic              sync_bank;
  logic              sync_ack;
  logic              rd_done;
  logic [AWIDTH-1:0] rd_addr;
  logic              rd_ce;
  logic [DWIDTH-1:0] rd_q;
  // BRAM ports
  logic [AWIDTH:0]   bram_addr1;
  logic              bram_ce1;
  logic              bram_we1;
  logic [DWIDTH-1:0] bram_d1;
  logic [AWIDTH:0]   bram_addr0;
  logic              bram_ce0;
  logic [DWIDTH-1:0] bram_q0;
  // status
  logic [15:0]       frames_done;
  logic              err_proto;

  modport slave (
    input  wr_req, wr_done, wr_addr, wr_ce, wr_we, wr_d,
    input  sync_ack, rd_done, rd_addr, rd_ce, bram_q0,
    output wr_grant, wr_bank, sync_vld, sync_bank, rd_q,
    output bram_addr1, bram_ce1, bram_we1, bram_d1,
    output bram_addr0, bram_ce0, frames_done, err_proto
  );

  modport master (
    output wr_req, wr_done, wr_addr, wr_ce, wr_we, wr_d,
    output sync_ack, rd_done, rd_addr, rd_ce, bram_q0,
    input  wr_grant, wr_bank, sync_vld, sync_bank, rd_q,
    input  bram_addr1, bram_ce1, bram_we1, bram_d1,
    input  bram_addr0, bram_ce0, frames_done, err_proto
  );
endinterface

// File: rtl/act_pingpong_sched.sv
// ---------------------------------------------------------------------------
// act_pingpong_sched
//   Ping-pong scheduler for a layer activation buffer. One dual-port BRAM is
//   split into two banks by the address MSB: the writer fills one bank while
//   the PE drains the other. Each bank walks EMPTY -> FILLING -> FULL ->
//   DRAINING -> EMPTY; wr_ptr / rd_ptr select the bank each side works on.
//   Ports:
//     ap_clk - clock, rising edge
//     ap_rst - synchronous, active-high reset
//     bus    - act_pingpong_sched_if.slave (writer, PE, BRAM and status)
// ---------------------------------------------------------------------------
module act_pingpong_sched #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  act_pingpong_sched_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // registered state
  bank_state_t bank_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic        sync_vld_q;
  logic        err_q;
  logic [15:0] frames_cnt;

  // next-state values
  bank_state_t bank_d [2];
  logic        wr_ptr_d;
  logic        rd_ptr_d;
  logic        sync_vld_d;
  logic        err_d;
  logic [15:0] frames_d;

  // event decode; each qualified event touches a bank in a distinct state,
  // so writer and PE events can never target the same bank in one cycle
  logic grant;
  logic wr_fill;
  logic wr_fin;
  logic sync_set;
  logic take;
  logic rd_fin;

  assign grant    = (bank_q[wr_ptr_q] == FILLING);
  assign wr_fill  = bus.wr_req  && (bank_q[wr_ptr_q] == EMPTY);
  assign wr_fin   = bus.wr_done && grant;
  assign sync_set = (bank_q[rd_ptr_q] == FULL) && !sync_vld_q;
  assign take     = sync_vld_q && bus.sync_ack;
  assign rd_fin   = bus.rd_done && (bank_q[rd_ptr_q] == DRAINING);

  // state register
  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (ap_rst) begin
      bank_q     <= '{EMPTY, EMPTY};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      sync_vld_q <= 1'b0;
      err_q      <= 1'b0;
      frames_cnt <= 16'd0;
    end else begin
      bank_q     <= bank_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sync_vld_q <= sync_vld_d;
      err_q      <= err_d;
      frames_cnt <= frames_d;
    end
  end

  // next-state logic
  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    bank_d     = bank_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sync_vld_d = sync_vld_q;
    err_d      = err_q;
    frames_d   = frames_cnt;

    if (wr_fill) begin
      bank_d[wr_ptr_q] = FILLING;
    end
    if (wr_fin) begin
      bank_d[wr_ptr_q] = FULL;
      wr_ptr_d         = ~wr_ptr_q;
    end

    // sync_vld is only ever set while bank[rd_ptr] is FULL, so an accepted
    // handshake always moves a FULL bank to DRAINING
    if (take) begin
      bank_d[rd_ptr_q] = DRAINING;
      sync_vld_d       = 1'b0;
    end else if (sync_set) begin
      sync_vld_d = 1'b1;
    end

    if (rd_fin) begin
      bank_d[rd_ptr_q] = EMPTY;
      rd_ptr_d         = ~rd_ptr_q;
      frames_d         = frames_cnt + 16'd1;
    end

    // protocol violations: the offending event is otherwise ignored
    if ((bus.wr_done && !grant) ||
        ((bus.wr_ce || bus.wr_we) && !grant) ||
        (bus.rd_done && !rd_fin) ||
        (bus.sync_ack && !sync_vld_q)) begin
      err_d = 1'b1;
    end
  end

  // outputs
  logic [AWIDTH:0]   wr_full_addr;
  logic [AWIDTH:0]   rd_full_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [DWIDTH-1:0] rd_data;

  always_comb begin
    wr_full_addr = {wr_ptr_q, bus.wr_addr};
    rd_full_addr = {rd_ptr_q, bus.rd_addr};
    wr_data      = bus.wr_d;
    rd_data      = bus.bram_q0;

    bus.wr_grant    = grant;
    bus.wr_bank     = wr_ptr_q;
    bus.sync_vld    = sync_vld_q;
    bus.sync_bank   = rd_ptr_q;
    bus.frames_done = frames_cnt;
    bus.err_proto   = err_q;

    // write strobes are dropped unless the writer owns the bank
    bus.bram_addr1 = wr_full_addr;
    bus.bram_ce1   = bus.wr_ce && grant;
    bus.bram_we1   = bus.wr_we && grant;
    bus.bram_d1    = wr_data;

    // read path is a pure mux, no added latency
    bus.bram_addr0 = rd_full_addr;
    bus.bram_ce0   = bus.rd_ce;
    bus.rd_q       = rd_data;
  end

endmodule
